// File: rtl/cochlea_readout_sched.sv
// Cochlea filter-bank readout scheduler: double-buffered channel snapshots
// streamed as one header word plus one data word per enabled channel.
module cochlea_readout_sched #(
  parameter int N_CH = 16
) (
  input  logic              clk_master,
  input  logic              rst,
  input  logic              sample_stb,
  input  logic [2*N_CH-1:0] read_out_I,
  input  logic [2*N_CH-1:0] read_out_Q,
  input  logic [N_CH-1:0]   ch_en,
  output logic [8:0]        dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        r_state;
  logic              r_pend_full;
  logic [2*N_CH-1:0] r_pend_i, r_pend_q;
  logic [N_CH-1:0]   r_pend_en;
  logic [2*N_CH-1:0] r_act_i, r_act_q;
  logic [N_CH-1:0]   r_rem;
  logic [7:0]        r_frame_cnt;
  logic [7:0]        r_ovr;

  logic              w_xfer, w_cap;
  logic [3:0]        w_idx;
  logic [N_CH-1:0]   w_low, w_rem_nxt;
  logic [1:0]        w_sel_i, w_sel_q;

  assign w_xfer = (r_state == S_IDLE) && r_pend_full;
  // A strobe may refill pending in the same cycle its old contents move to active.
  assign w_cap  = sample_stb && (!r_pend_full || w_xfer);

  // Lowest remaining channel: scan high to low so the last hit wins.
  always_comb begin
    w_idx   = 4'd0;
    w_low   = '0;
    w_sel_i = 2'd0;
    w_sel_q = 2'd0;
    for (int k = N_CH-1; k >= 0; k--) begin
      if (r_rem[k]) begin
        w_idx    = 4'(k);
        w_low    = '0;
        w_low[k] = 1'b1;
        w_sel_i  = r_act_i[2*k +: 2];
        w_sel_q  = r_act_q[2*k +: 2];
      end
    end
  end

  assign w_rem_nxt = r_rem & ~w_low;

  always_comb begin
    dout = 9'd0;
    case (r_state)
      S_HDR:   dout = {1'b1, r_frame_cnt};
      S_DATA:  dout = {1'b0, w_idx, w_sel_i, w_sel_q};
      default: dout = 9'd0;
    endcase
  end

  assign dout_valid  = (r_state != S_IDLE);
  assign busy        = dout_valid || r_pend_full;
  assign overrun_cnt = r_ovr;

  always_ff @(posedge clk_master) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend_full <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_ovr       <= 8'd0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (r_pend_full) begin
          r_rem   <= r_pend_en;
          r_state <= S_HDR;
        end
        S_HDR: if (dout_ready) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_state     <= (r_rem != '0) ? S_DATA : S_IDLE;
        end
        S_DATA: if (dout_ready) begin
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_cap)                              r_pend_full <= 1'b1;
      else if (w_xfer)                        r_pend_full <= 1'b0;
      else if (sample_stb && r_ovr != 8'hFF)  r_ovr       <= r_ovr + 8'd1;
    end
  end

  // Snapshot payloads carry no reset; their use is gated by pend_full and state.
  always_ff @(posedge clk_master) begin
    if (w_cap) begin
      r_pend_i  <= read_out_I;
      r_pend_q  <= read_out_Q;
      r_pend_en <= ch_en;
    end
    if (w_xfer) begin
      r_act_i <= r_pend_i;
      r_act_q <= r_pend_q;
    end
  end

endmodule

// File: tb/tb_cochlea_readout_sched.sv
// Bench for cochlea_readout_sched: vector table, corner sequences and a
// randomized run against a frame-queue reference model.
module tb_cochlea_readout_sched;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, stb, ready;
  logic [7:0]   I, Q;
  logic [3:0]   en;
  logic [8:0]   dout;
  logic         dout_valid, busy;
  logic [7:0]   overrun_cnt;

  cochlea_readout_sched #(.N_CH(N)) dut (
    .clk_master(clk), .rst(rst), .sample_stb(stb),
    .read_out_I(I), .read_out_Q(Q), .ch_en(en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(ready),
    .busy(busy), .overrun_cnt(overrun_cnt));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, hdr_seen = 0;

  // Reference model: words of the frame in flight, plus one pending snapshot.
  logic [8:0] m_act[$];
  logic       m_pv;
  logic [7:0] m_pi, m_pq;
  logic [3:0] m_pe;
  int         m_fc, m_ovr;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    bit was_empty, xfer, pv0;
    logic [8:0] w;
    was_empty = (m_act.size() == 0);
    xfer      = was_empty && m_pv;
    pv0       = m_pv;
    if (rst) begin
      m_act.delete(); m_pv = 0; m_fc = 0; m_ovr = 0;
      return;
    end
    if (!was_empty && ready) begin
      w = m_act.pop_front();
      if (w[8]) begin m_fc = (m_fc + 1) % 256; hdr_seen++; end
    end
    if (xfer) begin
      m_act.push_back({1'b1, 8'(m_fc)});
      for (int k = 0; k < N; k++)
        if (m_pe[k]) m_act.push_back({1'b0, 4'(k), m_pi[2*k +: 2], m_pq[2*k +: 2]});
    end
    if (stb && (!pv0 || xfer)) begin
      m_pv = 1; m_pi = I; m_pq = Q; m_pe = en;
    end else if (xfer) m_pv = 0;
    else if (stb && m_ovr < 255) m_ovr++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    chk("valid", int'(dout_valid), int'(m_act.size() > 0));
    if (m_act.size() > 0) chk("dout", int'(dout), int'(m_act[0]));
    chk("busy", int'(busy), int'((m_act.size() > 0) || m_pv));
    chk("overrun", int'(overrun_cnt), m_ovr);
  endtask

  task automatic do_reset();
    rst = 1; stb = 0; step(); rst = 0;
  endtask

  task automatic drain();
    stb = 0; ready = 1;
    for (int c = 0; c < 200 && busy; c++) step();
    chk("drain_timeout", int'(busy), 0);
  endtask

  typedef struct {
    bit         stb;
    logic [3:0] en;
    bit         exp_valid;
    logic [8:0] exp_dout;
    bit         exp_busy;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int h0;
    tbl[0]  = '{1, 4'hF, 0, 9'h000, 1};
    tbl[1]  = '{0, 4'hF, 1, 9'h100, 1};
    tbl[2]  = '{0, 4'hF, 1, 9'h003, 1};
    tbl[3]  = '{0, 4'hF, 1, 9'h016, 1};
    tbl[4]  = '{0, 4'hF, 1, 9'h029, 1};
    tbl[5]  = '{0, 4'hF, 1, 9'h03C, 1};
    tbl[6]  = '{0, 4'hF, 0, 9'h000, 0};
    tbl[7]  = '{1, 4'hA, 0, 9'h000, 1};
    tbl[8]  = '{0, 4'hA, 1, 9'h101, 1};
    tbl[9]  = '{0, 4'hA, 1, 9'h016, 1};
    tbl[10] = '{0, 4'hA, 1, 9'h03C, 1};
    tbl[11] = '{0, 4'hA, 0, 9'h000, 0};
    tbl[12] = '{1, 4'h0, 0, 9'h000, 1};
    tbl[13] = '{0, 4'h0, 1, 9'h102, 1};
    tbl[14] = '{0, 4'h0, 0, 9'h000, 0};
    tbl[15] = '{0, 4'h0, 0, 9'h000, 0};

    m_pv = 0; m_fc = 0; m_ovr = 0; m_pi = 0; m_pq = 0; m_pe = 0;
    stb = 0; ready = 1; en = 4'hF; I = 8'hE4; Q = 8'h1B;

    do_reset();
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun_cnt), 0);

    // Channel k carries I=k, Q=3-k.
    for (int i = 0; i < 16; i++) begin
      stb = tbl[i].stb; en = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_valid", i), int'(dout_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
    end

    // Overrun: third strobe under full backpressure is dropped.
    ready = 0; en = 4'hF;
    stb = 1; I = 8'h11; Q = 8'h22; step();
    I = 8'h33; Q = 8'h44; step();
    I = 8'hFF; Q = 8'hFF; step();
    stb = 0; step();
    chk("ovr_one", int'(overrun_cnt), 1);
    chk("ovr_valid", int'(dout_valid), 1);
    chk("ovr_busy", int'(busy), 1);
    stb = 1;
    for (int i = 0; i < 300; i++) step();
    stb = 0; step();
    chk("ovr_sat", int'(overrun_cnt), 255);
    drain();

    // Strobe coinciding with the IDLE transfer.
    do_reset();
    h0 = hdr_seen; ready = 1; en = 4'hF;
    stb = 1; I = 8'h5A; Q = 8'hA5; step();
    I = 8'hC3; Q = 8'h3C; step();
    drain();
    chk("xfer_ovr", int'(overrun_cnt), 0);
    chk("xfer_frames", hdr_seen - h0, 2);

    // Reset while channel 2 of 4 is presented; simultaneous strobe is lost.
    do_reset();
    I = 8'hE4; Q = 8'h1B; en = 4'hF;
    stb = 1; step(); stb = 0;
    step(); step(); step(); step();
    chk("mid_ch2", int'(dout), 9'h029);
    rst = 1; stb = 1; step(); rst = 0; stb = 0;
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    step();
    chk("mid_stb_lost", int'(busy), 0);
    chk("mid_stb_ovr", int'(overrun_cnt), 0);
    stb = 1; step(); stb = 0; step();
    chk("mid_hdr", int'(dout), 9'h100);
    drain();

    // frame_cnt wraps after 256 header-only frames.
    do_reset();
    h0 = hdr_seen; en = 4'h0; ready = 1;
    for (int f = 0; f < 256; f++) begin
      stb = 1; step(); stb = 0; step(); step();
    end
    chk("wrap_count", hdr_seen - h0, 256);
    stb = 1; step(); stb = 0; step();
    chk("wrap_hdr", int'(dout), 9'h100);
    drain();

    // Randomized strobes, data, masks and backpressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stb   = ($urandom % 6) == 0;
      I     = 8'($urandom);
      Q     = 8'($urandom);
      en    = 4'($urandom);
      ready = (c % 500 < 60) ? 1'b0 : (($urandom % 3) != 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
